// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the M-stage exception controller:
// exception codes, CP0 register numbers and register bit positions.
package exception_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_NONE = 5'b11111;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int CA_EXC_LO = 2;
   localparam int CA_IP_LO  = 8;
   localparam int CA_HW_LO  = 10;
   localparam int CA_IP7    = 15;
   localparam int CA_TI     = 30;
   localparam int CA_BD     = 31;

   localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
   // IM[15:8], EXL and IE are the only software-writable Status bits
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Fixed-priority encoder: exception/interrupt flags to a 5-bit ExcCode.
// Interrupts outrank every synchronous flag; ERET is lowest.
module exc_prio_enc
   import exception_ctrl_pkg::*;
#(
   parameter logic [4:0] ERET_CODE = 5'b01110
) (
   input  logic       i_int,
   input  logic       i_pc_error,
   input  logic       i_ri,
   input  logic       i_ov,
   input  logic       i_bp,
   input  logic       i_sys,
   input  logic       i_adel,
   input  logic       i_ades,
   input  logic       i_eret,
   output logic [4:0] o_code
);

   always_comb begin
      o_code = EXC_NONE;
      if (i_int)           o_code = EXC_INT;
      else if (i_pc_error) o_code = EXC_ADEL;
      else if (i_ri)       o_code = EXC_RI;
      else if (i_ov)       o_code = EXC_OV;
      else if (i_bp)       o_code = EXC_BP;
      else if (i_sys)      o_code = EXC_SYS;
      else if (i_adel)     o_code = EXC_ADEL;
      else if (i_ades)     o_code = EXC_ADES;
      else if (i_eret)     o_code = ERET_CODE;
   end

endmodule

// File: rtl/exception_ctrl.sv
// M-stage exception/interrupt controller with CP0 Status, Cause, EPC,
// BadVAddr and Count/Compare; drives flush and PC redirect.
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter int          HW_INT_NUM = 6,
   parameter bit          TIMER_EN   = 1'b1,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [4:0]  ERET_CODE  = 5'b01110
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallM,
   input  logic                  pc_error,
   input  logic                  ri,
   input  logic                  ov,
   input  logic                  bp,
   input  logic                  sys,
   input  logic                  addr_error_lw,
   input  logic                  addr_error_sw,
   input  logic                  eretM,
   input  logic                  is_in_delayslotM,
   input  logic [31:0]           pcM,
   input  logic [31:0]           ALUOutM,
   input  logic [HW_INT_NUM-1:0] ext_int,
   input  logic                  cp0_we,
   input  logic [4:0]            cp0_waddr,
   input  logic [31:0]           cp0_wdata,
   input  logic [4:0]            cp0_raddr,
   output logic [31:0]           cp0_rdata,
   output logic [4:0]            exception_code,
   output logic                  exception_flush,
   output logic                  pc_trap,
   output logic [31:0]           new_pc,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o
);

   logic [31:0] r_status;
   logic [31:0] r_cause;
   logic [31:0] r_epc;
   logic [31:0] r_badvaddr;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_tick;

   logic [31:0] w_cause;
   logic        w_int;
   logic [4:0]  w_code;
   logic        w_flush;
   logic        w_eret;
   logic        w_commit;
   logic        w_mtc0;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic [31:0] w_count_nxt;

   // The timer request is folded into IP7 on the architectural view
   assign w_cause = {r_cause[31:16],
                     r_cause[CA_IP7] | (TIMER_EN & r_cause[CA_TI]),
                     r_cause[14:0]};

   assign w_int = r_status[ST_IE] & ~r_status[ST_EXL]
                & |(r_status[15:8] & w_cause[15:8]);

   exc_prio_enc #(
      .ERET_CODE (ERET_CODE)
   ) u_prio (
      .i_int      (w_int),
      .i_pc_error (pc_error),
      .i_ri       (ri),
      .i_ov       (ov),
      .i_bp       (bp),
      .i_sys      (sys),
      .i_adel     (addr_error_lw),
      .i_ades     (addr_error_sw),
      .i_eret     (eretM),
      .o_code     (w_code)
   );

   assign w_flush  = (w_code != EXC_NONE) & ~stallM;
   assign w_eret   = (w_code == ERET_CODE);
   assign w_commit = w_flush & ~w_eret;
   assign w_mtc0   = cp0_we & ~w_flush & ~stallM;

   assign w_wr_count   = w_mtc0 & (cp0_waddr == CP0_COUNT);
   assign w_wr_compare = w_mtc0 & (cp0_waddr == CP0_COMPARE);
   assign w_count_nxt  = w_wr_count ? cp0_wdata
                                    : r_count + {31'd0, r_tick};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status   <= STATUS_RST;
         r_cause    <= 32'd0;
         r_epc      <= 32'd0;
         r_badvaddr <= 32'd0;
         r_count    <= 32'd0;
         r_compare  <= 32'd0;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= ~r_tick;
         r_cause[CA_HW_LO +: HW_INT_NUM] <= ext_int;
         if (TIMER_EN) begin
            r_count <= w_count_nxt;
            if (w_wr_compare) begin
               r_compare      <= cp0_wdata;
               r_cause[CA_TI] <= 1'b0;
            end else if (r_compare != 32'd0 &&
                         w_count_nxt == r_compare) begin
               r_cause[CA_TI] <= 1'b1;
            end
         end
         if (w_commit) begin
            r_status[ST_EXL] <= 1'b1;
            r_cause[6:2]     <= w_code;
            // A nested exception keeps the original return point
            if (!r_status[ST_EXL]) begin
               r_cause[CA_BD] <= is_in_delayslotM;
               r_epc <= is_in_delayslotM ? pcM - 32'd4 : pcM;
            end
            if (w_code == EXC_ADEL && pc_error)
               r_badvaddr <= pcM;
            else if (w_code == EXC_ADEL || w_code == EXC_ADES)
               r_badvaddr <= ALUOutM;
         end else if (w_flush) begin
            r_status[ST_EXL] <= 1'b0;
         end else if (w_mtc0) begin
            case (cp0_waddr)
               CP0_STATUS: r_status <= (r_status & ~STATUS_WMASK)
                                     | (cp0_wdata & STATUS_WMASK);
               CP0_CAUSE:  r_cause[9:8] <= cp0_wdata[9:8];
               CP0_EPC:    r_epc <= cp0_wdata;
               default:    ;
            endcase
         end
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_raddr)
         CP0_BADVADDR: cp0_rdata = r_badvaddr;
         CP0_COUNT:    cp0_rdata = r_count;
         CP0_COMPARE:  cp0_rdata = r_compare;
         CP0_STATUS:   cp0_rdata = r_status;
         CP0_CAUSE:    cp0_rdata = w_cause;
         CP0_EPC:      cp0_rdata = r_epc;
         default:      cp0_rdata = 32'd0;
      endcase
   end

   assign exception_code  = w_code;
   assign exception_flush = w_flush;
   assign pc_trap         = w_flush;
   assign new_pc          = w_eret ? r_epc : EXC_VECTOR;
   assign status_o        = r_status;
   assign cause_o         = w_cause;
   assign epc_o           = r_epc;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus queues expected
// {code,new_pc} per flush, a negedge monitor pops and compares.
module tb_exception_ctrl;

   localparam logic [31:0] VEC  = 32'hBFC00380;
   localparam logic [4:0]  ERET = 5'b01110;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallM, pc_error, ri, ov, bp, sys;
   logic        addr_error_lw, addr_error_sw, eretM;
   logic        is_in_delayslotM;
   logic [31:0] pcM, ALUOutM;
   logic [5:0]  ext_int;
   logic        cp0_we;
   logic [4:0]  cp0_waddr, cp0_raddr;
   logic [31:0] cp0_wdata, cp0_rdata;
   logic [4:0]  exception_code;
   logic        exception_flush, pc_trap;
   logic [31:0] new_pc, status_o, cause_o, epc_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   exception_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .stallM           (stallM),
      .pc_error         (pc_error),
      .ri               (ri),
      .ov               (ov),
      .bp               (bp),
      .sys              (sys),
      .addr_error_lw    (addr_error_lw),
      .addr_error_sw    (addr_error_sw),
      .eretM            (eretM),
      .is_in_delayslotM (is_in_delayslotM),
      .pcM              (pcM),
      .ALUOutM          (ALUOutM),
      .ext_int          (ext_int),
      .cp0_we           (cp0_we),
      .cp0_waddr        (cp0_waddr),
      .cp0_wdata        (cp0_wdata),
      .cp0_raddr        (cp0_raddr),
      .cp0_rdata        (cp0_rdata),
      .exception_code   (exception_code),
      .exception_flush  (exception_flush),
      .pc_trap          (pc_trap),
      .new_pc           (new_pc),
      .status_o         (status_o),
      .cause_o          (cause_o),
      .epc_o            (epc_o)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      stallM = 0; pc_error = 0; ri = 0; ov = 0; bp = 0; sys = 0;
      addr_error_lw = 0; addr_error_sw = 0; eretM = 0;
      is_in_delayslotM = 0; cp0_we = 0;
   endtask

   task automatic expect_flush(input logic [4:0] c,
                               input logic [31:0] pc);
      exp_q.push_back({c, pc});
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
      cyc();
      cp0_we = 0;
   endtask

   task automatic rd(input string nm, input logic [4:0] a,
                     input logic [31:0] exp);
      cp0_raddr = a;
      #1;
      check(nm, cp0_rdata, exp);
   endtask

   // Monitor: every flush must match the oldest queued expectation
   always @(negedge clk) begin
      if (!rst && exception_flush) begin
         logic [36:0] e;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mon_unexpected: code %h pc %h expected none",
                     exception_code, new_pc);
         end else begin
            e = exp_q.pop_front();
            if (exception_code !== e[36:32] || new_pc !== e[31:0]
                || pc_trap !== 1'b1) begin
               n_fail++;
               $display("FAIL mon_flush: got %h/%h expected %h/%h",
                        exception_code, new_pc, e[36:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1; clr();
      pcM = 0; ALUOutM = 0; ext_int = 0;
      cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 0;
      repeat (2) cyc();
      check("rst_status", status_o, 32'h0040_0000);
      check("rst_cause", cause_o, 32'h0);
      check("rst_epc", epc_o, 32'h0);
      check("rst_code", {27'd0, exception_code}, 32'h1f);
      check("rst_flush", {30'd0, exception_flush, pc_trap}, 32'h0);
      rst = 0;

      // syscall
      sys = 1; pcM = 32'hBFC00100;
      expect_flush(5'd8, VEC);
      cyc(); clr();
      check("sys_epc", epc_o, 32'hBFC00100);
      check("sys_exl", {31'd0, status_o[1]}, 32'h1);
      check("sys_exc", {27'd0, cause_o[6:2]}, 32'd8);
      rd("sys_bva", 5'd8, 32'h0);

      eretM = 1;
      expect_flush(ERET, 32'hBFC00100);
      cyc(); clr();
      check("eret1_exl", {31'd0, status_o[1]}, 32'h0);

      // overflow beats store error, delay slot
      ov = 1; addr_error_sw = 1; is_in_delayslotM = 1;
      pcM = 32'h80001004; ALUOutM = 32'h12345678;
      expect_flush(5'd12, VEC);
      cyc(); clr();
      check("ov_epc", epc_o, 32'h80001000);
      check("ov_bd", {31'd0, cause_o[31]}, 32'h1);
      check("ov_exc", {27'd0, cause_o[6:2]}, 32'd12);
      rd("ov_bva", 5'd8, 32'h0);

      eretM = 1;
      expect_flush(ERET, 32'h80001000);
      cyc(); clr();

      // load address error
      addr_error_lw = 1; ALUOutM = 32'h80000003; pcM = 32'h80002000;
      expect_flush(5'd4, VEC);
      cyc(); clr();
      rd("lw_bva", 5'd8, 32'h80000003);
      check("lw_epc", epc_o, 32'h80002000);
      check("lw_bd", {31'd0, cause_o[31]}, 32'h0);

      // nested: EPC kept, ExcCode updated
      bp = 1; pcM = 32'h80003000;
      expect_flush(5'd9, VEC);
      cyc(); clr();
      check("nest_epc", epc_o, 32'h80002000);
      check("nest_exc", {27'd0, cause_o[6:2]}, 32'd9);

      eretM = 1;
      expect_flush(ERET, 32'h80002000);
      cyc(); clr();
      check("eret3_exl", {31'd0, status_o[1]}, 32'h0);

      // external interrupt on IP2
      ext_int = 6'b000001;
      cyc();
      mtc0(5'd12, 32'h0000_0401);
      check("int_code", {27'd0, exception_code}, 32'd0);
      pcM = 32'h80004000;
      expect_flush(5'd0, VEC);
      cyc(); clr();
      check("int_exl", {31'd0, status_o[1]}, 32'h1);
      check("int_epc", epc_o, 32'h80004000);
      check("int_masked", {27'd0, exception_code}, 32'h1f);
      cyc();
      eretM = 1; ext_int = 0;
      expect_flush(ERET, 32'h80004000);
      cyc(); clr();
      check("int_off", {27'd0, exception_code}, 32'h1f);

      // timer
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd10);
      rd("cmp_rd", 5'd11, 32'd10);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (cause_o[30]) seen = 1;
         else cyc();
      end
      check("ti_seen", {31'd0, seen}, 32'h1);
      rd("ti_count", 5'd9, 32'd10);
      check("ti_ip7", {31'd0, cause_o[15]}, 32'h1);
      check("ti_masked", {27'd0, exception_code}, 32'h1f);
      mtc0(5'd12, 32'h0000_8001);
      pcM = 32'h80005000;
      expect_flush(5'd0, VEC);
      cyc(); clr();
      check("ti_exc", {27'd0, cause_o[6:2]}, 32'd0);
      mtc0(5'd11, 32'd0);
      check("ti_clr", {31'd0, cause_o[30]}, 32'h0);
      eretM = 1;
      expect_flush(ERET, 32'h80005000);
      cyc(); clr();

      // stall holds the reserved-instruction exception
      stallM = 1; ri = 1; pcM = 32'h80006000;
      #1;
      check("stall_flush", {30'd0, exception_flush, pc_trap}, 32'h0);
      cyc();
      check("stall_exl", {31'd0, status_o[1]}, 32'h0);
      check("stall_epc", epc_o, 32'h80005000);
      stallM = 0;
      expect_flush(5'd10, VEC);
      cyc(); clr();
      check("ri_epc", epc_o, 32'h80006000);
      check("ri_exc", {27'd0, cause_o[6:2]}, 32'd10);

      cyc();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
